sub_array_fifo: RTL and testbench

Parametrised successor to the array-port sub-block. It carries the same bundle of signal shapes (single bit, vector, 2D packed array, 2D unpacked array) from an input side to an output side, through a DEPTH-entry FIFO with valid/ready handshakes on both sides. A REVERSE mode optionally reverses the array element order on the output. It sits between a producer and a consumer that exchange array-shaped bundles and need rate decoupling.

---
 rtl/sub_array_fifo_if.sv | 37 +++
 rtl/sub_array_fifo.sv | 83 ++++++++
 tb/tb_sub_array_fifo.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_array_fifo_if.sv
// Bundle-stream interface for sub_array_fifo: producer side (in_*, sig_a..sig_d)
// and consumer side (out_*, sig_e..sig_h), plus the occupancy count.
interface sub_array_fifo_if #(
    parameter int W     = 2,
    parameter int N     = 3,
    parameter int EW    = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic                 sig_a;
    logic [W-1:0]         sig_b;
    logic [0:N-1][EW-1:0] sig_c;
    logic [EW-1:0]        sig_d [N];

    logic                 out_valid;
    logic                 out_ready;
    logic                 sig_e;
    logic [W-1:0]         sig_f;
    logic [0:N-1][EW-1:0] sig_g;
    logic [EW-1:0]        sig_h [N];

    logic [CW-1:0]        count;

    // master drives bundles in and takes them out; slave is the FIFO itself
    modport master (
        output in_valid, sig_a, sig_b, sig_c, sig_d, out_ready,
        input  in_ready, out_valid, sig_e, sig_f, sig_g, sig_h, count
    );

    modport slave (
        input  in_valid, sig_a, sig_b, sig_c, sig_d, out_ready,
        output in_ready, out_valid, sig_e, sig_f, sig_g, sig_h, count
    );
endinterface

// File: rtl/sub_array_fifo.sv
// DEPTH-entry valid/ready FIFO carrying a bundle of scalar, vector, packed-array
// and unpacked-array signals, with optional element-order reversal on the output.
module sub_array_fifo #(
    parameter int W       = 2,
    parameter int N       = 3,
    parameter int EW      = 8,
    parameter int DEPTH   = 4,
    parameter bit REVERSE = 1'b0
) (
    input logic              clk,
    input logic              rst,
    sub_array_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic                 mem_a [DEPTH];
    logic [W-1:0]         mem_b [DEPTH];
    logic [0:N-1][EW-1:0] mem_c [DEPTH];
    logic [EW-1:0]        mem_d [DEPTH][N];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    // Handshakes come from the count register only, so in_ready never sees out_ready.
    assign bus.in_ready  = (count_q != FULL_COUNT);
    assign bus.out_valid = (count_q != '0);
    assign bus.count     = count_q;
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                mem_a[e] <= 1'b0;
                mem_b[e] <= '0;
                mem_c[e] <= '0;
                for (int i = 0; i < N; i++) begin
                    mem_d[e][i] <= '0;
                end
            end
        end else begin
            if (push) begin
                mem_a[wr_ptr] <= bus.sig_a;
                mem_b[wr_ptr] <= bus.sig_b;
                mem_c[wr_ptr] <= bus.sig_c;
                for (int i = 0; i < N; i++) begin
                    mem_d[wr_ptr][i] <= bus.sig_d[i];
                end
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head entry is always visible; reversal only permutes array elements.
    always_comb begin
        bus.sig_e = mem_a[rd_ptr];
        bus.sig_f = mem_b[rd_ptr];
        bus.sig_g = '0;
        for (int i = 0; i < N; i++) begin
            bus.sig_h[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            bus.sig_g[i] = mem_c[rd_ptr][REVERSE ? (N - 1 - i) : i];
            bus.sig_h[i] = mem_d[rd_ptr][REVERSE ? (N - 1 - i) : i];
        end
    end
endmodule

// File: tb/tb_sub_array_fifo.sv
// Scoreboard bench for sub_array_fifo: a normal instance driven through all
// queue scenarios and a REVERSE=1 instance for element reordering.
module tb_sub_array_fifo;
    localparam int W     = 2;
    localparam int N     = 3;
    localparam int EW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                 a;
        logic [W-1:0]         b;
        logic [0:N-1][EW-1:0] c;
        logic [0:N-1][EW-1:0] d;
    } bundle_t;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    int      tests_run = 0;
    int      tests_failed = 0;
    int      model_count = 0;
    bundle_t exp_q [$];
    bundle_t in_bundle;
    bundle_t spec_bundle;
    bundle_t rev_expected;
    bundle_t obs;

    sub_array_fifo_if #(.W(W), .N(N), .EW(EW), .DEPTH(DEPTH)) bus ();
    sub_array_fifo_if #(.W(W), .N(N), .EW(EW), .DEPTH(DEPTH)) rbus ();

    sub_array_fifo #(.W(W), .N(N), .EW(EW), .DEPTH(DEPTH), .REVERSE(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sub_array_fifo #(.W(W), .N(N), .EW(EW), .DEPTH(DEPTH), .REVERSE(1'b1)) dut_rev (
        .clk (clk),
        .rst (rst),
        .bus (rbus)
    );

    always #5 clk = ~clk;

    function automatic bundle_t make_bundle(input int v);
        bundle_t x;
        x.a = v[0];
        x.b = v[W-1:0];
        for (int i = 0; i < N; i++) begin
            x.c[i] = 8'(v * 16 + i);
            x.d[i] = 8'(8'hA0 + v + 3 * i);
        end
        return x;
    endfunction

    function automatic bundle_t observed();
        bundle_t o;
        o.a = bus.sig_e;
        o.b = bus.sig_f;
        o.c = bus.sig_g;
        for (int i = 0; i < N; i++) o.d[i] = bus.sig_h[i];
        return o;
    endfunction

    function automatic bundle_t observed_rev();
        bundle_t o;
        o.a = rbus.sig_e;
        o.b = rbus.sig_f;
        o.c = rbus.sig_g;
        for (int i = 0; i < N; i++) o.d[i] = rbus.sig_h[i];
        return o;
    endfunction

    task automatic drive(input bundle_t x);
        in_bundle = x;
        bus.sig_a = x.a;
        bus.sig_b = x.b;
        bus.sig_c = x.c;
        for (int i = 0; i < N; i++) bus.sig_d[i] = x.d[i];
    endtask

    // Advances one edge and updates the expected-queue model from the bench's own occupancy count.
    task automatic tick();
        bit push;
        bit pop;
        push = bus.in_valid && (model_count != DEPTH);
        pop  = bus.out_ready && (model_count != 0);
        if (rst) begin
            exp_q.delete();
            model_count = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back(in_bundle);
            model_count = model_count + int'(push) - int'(pop);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(make_bundle(9));
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        for (int phase = 0; phase < 3; phase++) begin
            if (phase == 1) begin
                rst = 1'b0;
                bus.in_valid = 1'b0;
                bus.out_ready = 1'b0;
            end
            if (phase == 2) tick();
            tests_run++;
            if (bus.out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_out_valid phase %0d: got %b, expected 0", phase, bus.out_valid);
            end
            tests_run++;
            if (bus.in_ready !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL reset_in_ready phase %0d: got %b, expected 1", phase, bus.in_ready);
            end
            tests_run++;
            if (bus.count !== CW'(0)) begin
                tests_failed++;
                $display("[TB] FAIL reset_count phase %0d: got %0d, expected 0", phase, bus.count);
            end
            tests_run++;
            obs = observed();
            if (obs !== bundle_t'(0)) begin
                tests_failed++;
                $display("[TB] FAIL reset_data phase %0d: got %h, expected 0", phase, obs);
            end
            tests_run++;
            obs = observed_rev();
            if (obs !== bundle_t'(0) || rbus.out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_rev phase %0d: got %h valid %b, expected 0 valid 0", phase, obs, rbus.out_valid);
            end
        end
    endtask

    task automatic test_single();
        drive(spec_bundle);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.count !== CW'(1)) begin
            tests_failed++;
            $display("[TB] FAIL single_valid: got valid %b count %0d, expected valid 1 count 1", bus.out_valid, bus.count);
        end
        tests_run++;
        obs = observed();
        if (obs !== exp_q[0]) begin
            tests_failed++;
            $display("[TB] FAIL single_data: got %h, expected %h", obs, exp_q[0]);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.count !== CW'(0)) begin
            tests_failed++;
            $display("[TB] FAIL single_pop: got valid %b count %0d, expected valid 0 count 0", bus.out_valid, bus.count);
        end
    endtask

    task automatic test_fill();
        bus.out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            drive(make_bundle(v));
            bus.in_valid = 1'b1;
            tests_run++;
            if (bus.in_ready !== (v <= 4)) begin
                tests_failed++;
                $display("[TB] FAIL fill_in_ready bundle %0d: got %b, expected %b", v, bus.in_ready, (v <= 4));
            end
            tick();
        end
        tests_run++;
        if (bus.count !== CW'(4) || bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fill_full: got count %0d in_ready %b, expected count 4 in_ready 0", bus.count, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        tests_run++;
        obs = observed();
        if (obs !== exp_q[0]) begin
            tests_failed++;
            $display("[TB] FAIL fill_first_pop: got %h, expected %h", obs, exp_q[0]);
        end
        tick();
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.count !== CW'(3)) begin
            tests_failed++;
            $display("[TB] FAIL fill_after_pop: got in_ready %b count %0d, expected in_ready 1 count 3", bus.in_ready, bus.count);
        end
        tick();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.count !== CW'(4)) begin
            tests_failed++;
            $display("[TB] FAIL fill_refill: got count %0d, expected 4", bus.count);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            obs = observed();
            if (bus.out_valid !== 1'b1 || obs !== make_bundle(k + 2)) begin
                tests_failed++;
                $display("[TB] FAIL fill_drain %0d: got %h valid %b, expected %h valid 1", k, obs, bus.out_valid, make_bundle(k + 2));
            end
            tick();
        end
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL fill_empty: got %b, expected 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            if (j < 10) begin
                drive(make_bundle(30 + j));
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (j > 0) begin
                tests_run++;
                if (bus.out_valid !== 1'b1 || bus.count !== CW'(1)) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_level %0d: got valid %b count %0d, expected valid 1 count 1", j, bus.out_valid, bus.count);
                end
                tests_run++;
                obs = observed();
                if (obs !== exp_q[0]) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_data %0d: got %h, expected %h", j, obs, exp_q[0]);
                end
            end
            tick();
        end
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.count !== CW'(0)) begin
            tests_failed++;
            $display("[TB] FAIL stream_end: got valid %b count %0d, expected valid 0 count 0", bus.out_valid, bus.count);
        end
    endtask

    task automatic test_reverse();
        rbus.sig_a = spec_bundle.a;
        rbus.sig_b = spec_bundle.b;
        rbus.sig_c = spec_bundle.c;
        for (int i = 0; i < N; i++) rbus.sig_d[i] = spec_bundle.d[i];
        rbus.in_valid = 1'b1;
        rbus.out_ready = 1'b0;
        tick();
        rbus.in_valid = 1'b0;
        tests_run++;
        obs = observed_rev();
        if (rbus.out_valid !== 1'b1 || obs !== rev_expected) begin
            tests_failed++;
            $display("[TB] FAIL reverse_data: got %h valid %b, expected %h valid 1", obs, rbus.out_valid, rev_expected);
        end
        rbus.out_ready = 1'b1;
        tick();
        rbus.out_ready = 1'b0;
        tests_run++;
        if (rbus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reverse_pop: got %b, expected 0", rbus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int v = 20; v < 23; v++) begin
            drive(make_bundle(v));
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.count !== CW'(3) || bus.out_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_before: got count %0d valid %b, expected count 3 valid 1", bus.count, bus.out_valid);
        end
        rst = 1'b1;
        drive(make_bundle(99));
        bus.in_valid = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.count !== CW'(0) || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_cleared: got count %0d valid %b ready %b, expected count 0 valid 0 ready 1",
                     bus.count, bus.out_valid, bus.in_ready);
        end
        drive(make_bundle(7));
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tests_run++;
        obs = observed();
        if (bus.out_valid !== 1'b1 || bus.count !== CW'(1) || obs !== make_bundle(7)) begin
            tests_failed++;
            $display("[TB] FAIL midreset_first: got %h valid %b count %0d, expected %h valid 1 count 1",
                     obs, bus.out_valid, bus.count, make_bundle(7));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.count !== CW'(0)) begin
            tests_failed++;
            $display("[TB] FAIL midreset_stale: got valid %b count %0d, expected valid 0 count 0", bus.out_valid, bus.count);
        end
    endtask

    initial begin
        spec_bundle.a = 1'b1;
        spec_bundle.b = 2'b10;
        spec_bundle.c = {8'h11, 8'h22, 8'h33};
        spec_bundle.d = {8'hA0, 8'hA1, 8'hA2};
        rev_expected.a = 1'b1;
        rev_expected.b = 2'b10;
        rev_expected.c = {8'h33, 8'h22, 8'h11};
        rev_expected.d = {8'hA2, 8'hA1, 8'hA0};

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive(bundle_t'(0));
        rbus.in_valid = 1'b0;
        rbus.out_ready = 1'b0;
        rbus.sig_a = 1'b0;
        rbus.sig_b = '0;
        rbus.sig_c = '0;
        for (int i = 0; i < N; i++) rbus.sig_d[i] = '0;

        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_reverse();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
